// File: rtl/fsmc_mux_master_if.sv
// Local request/response port plus multiplexed AD bus pins of the FSMC-style bus initiator.
// master = initiator side, slave = local requester / bus responder side.
interface fsmc_mux_master_if;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned AHI_W  = 3;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              ne_n;
    logic              nadv;
    logic              noe_n;
    logic              nwe_n;
    logic [AHI_W-1:0]  a_hi;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, ad_in,
        output req_ready, rsp_valid, rsp_rdata,
        output ne_n, nadv, noe_n, nwe_n, a_hi, ad_out, ad_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, ad_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ne_n, nadv, noe_n, nwe_n, a_hi, ad_out, ad_oe
    );
endinterface

// File: rtl/fsmc_mux_master.sv
// Multiplexed address/data bus initiator: one local request becomes one bus cycle
// (address, address hold, data, turnaround) with programmable phase lengths.
module fsmc_mux_master #(
    parameter int unsigned ADDSET  = 2,
    parameter int unsigned ADDHLD  = 1,
    parameter int unsigned DATAST  = 4,
    parameter int unsigned BUSTURN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    fsmc_mux_master_if.master  bus
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned AHI_W   = 3;

    // Zero-length phases are stretched to one cycle.
    localparam int unsigned ADDSET_L  = (ADDSET  < 1) ? 1 : ADDSET;
    localparam int unsigned ADDHLD_L  = (ADDHLD  < 1) ? 1 : ADDHLD;
    localparam int unsigned DATAST_L  = (DATAST  < 1) ? 1 : DATAST;
    localparam int unsigned BUSTURN_L = (BUSTURN < 1) ? 1 : BUSTURN;

    localparam logic [CNT_W-1:0] ADDSET_LD  = CNT_W'(ADDSET_L  - 1);
    localparam logic [CNT_W-1:0] ADDHLD_LD  = CNT_W'(ADDHLD_L  - 1);
    localparam logic [CNT_W-1:0] DATAST_LD  = CNT_W'(DATAST_L  - 1);
    localparam logic [CNT_W-1:0] BUSTURN_LD = CNT_W'(BUSTURN_L - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_AHOLD = 3'd2,
        S_DATA  = 3'd3,
        S_TURN  = 3'd4
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                ne_n_q;
    logic                nadv_q;
    logic                noe_n_q;
    logic                nwe_n_q;
    logic [AHI_W-1:0]    a_hi_q;
    logic [DATA_W-1:0]   ad_out_q;
    logic                ad_oe_q;

    logic                last_c;
    assign last_c = (cnt_q == '0);

    // Bus cycle sequencer; cnt_q holds the remaining cycles of the current phase minus one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ne_n_q      <= 1'b1;
            nadv_q      <= 1'b1;
            noe_n_q     <= 1'b1;
            nwe_n_q     <= 1'b1;
            a_hi_q      <= '0;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        state_q  <= S_ADDR;
                        cnt_q    <= ADDSET_LD;
                        write_q  <= bus.req_write;
                        wdata_q  <= bus.req_wdata;
                        ready_q  <= 1'b0;
                        ne_n_q   <= 1'b0;
                        nadv_q   <= 1'b0;
                        a_hi_q   <= bus.req_addr[18:16];
                        ad_out_q <= bus.req_addr[15:0];
                        ad_oe_q  <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (last_c) begin
                        state_q <= S_AHOLD;
                        cnt_q   <= ADDHLD_LD;
                        nadv_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_AHOLD: begin
                    if (last_c) begin
                        state_q <= S_DATA;
                        cnt_q   <= DATAST_LD;
                        if (write_q) begin
                            ad_out_q <= wdata_q;
                            nwe_n_q  <= 1'b0;
                        end else begin
                            ad_oe_q <= 1'b0;
                            noe_n_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (last_c) begin
                        state_q     <= S_TURN;
                        cnt_q       <= BUSTURN_LD;
                        ne_n_q      <= 1'b1;
                        noe_n_q     <= 1'b1;
                        nwe_n_q     <= 1'b1;
                        ad_oe_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        if (!write_q) begin
                            rsp_rdata_q <= bus.ad_in;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_TURN: begin
                    if (last_c) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    ne_n_q  <= 1'b1;
                    nadv_q  <= 1'b1;
                    noe_n_q <= 1'b1;
                    nwe_n_q <= 1'b1;
                    ad_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ne_n      = ne_n_q;
    assign bus.nadv      = nadv_q;
    assign bus.noe_n     = noe_n_q;
    assign bus.nwe_n     = nwe_n_q;
    assign bus.a_hi      = a_hi_q;
    assign bus.ad_out    = ad_out_q;
    assign bus.ad_oe     = ad_oe_q;

endmodule

// File: tb/tb_fsmc_mux_master.sv
// Bench for fsmc_mux_master: random traffic against a memory-backed bus responder,
// with a scoreboard of expected responses and per-cycle bus protocol monitoring.
module tb_fsmc_mux_master;
    localparam int unsigned T_ADDSET  = 2;
    localparam int unsigned T_ADDHLD  = 1;
    localparam int unsigned T_DATAST  = 4;
    localparam int unsigned T_BUSTURN = 1;
    localparam int unsigned LAT       = T_ADDSET + T_ADDHLD + T_DATAST;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fsmc_mux_master_if bus ();
    fsmc_mux_master_if bus2 ();

    fsmc_mux_master #(
        .ADDSET(T_ADDSET), .ADDHLD(T_ADDHLD), .DATAST(T_DATAST), .BUSTURN(T_BUSTURN)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    // Zero settings must behave as one-cycle phases.
    fsmc_mux_master #(
        .ADDSET(0), .ADDHLD(1), .DATAST(0), .BUSTURN(1)
    ) u_dut2 (
        .clk  (clk),
        .rst_n(rst2_n),
        .bus  (bus2.master)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        write;
        logic [18:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int unsigned rsp_cyc;
        bit          b2b;
    } txn_t;

    txn_t sb[$];

    // Reference model: word memory and last read value seen at the response port.
    logic [15:0] ref_mem [logic [18:0]];
    logic [15:0] ref_last_rd = 16'h0000;

    function automatic logic [15:0] dflt(input logic [18:0] a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    // Bus responder: address latch on NADV rise, write on NWE rise, read data valid late in the strobe.
    logic [15:0] bus_mem [logic [18:0]];
    logic [18:0] latch_q = '0;
    int          rd_run  = 0;

    always @(posedge bus.nadv) if (rst_n) latch_q = {bus.a_hi, bus.ad_out};
    always @(posedge bus.nwe_n) if (rst_n) bus_mem[latch_q] = bus.ad_out;
    always @(negedge clk) rd_run <= (!bus.noe_n) ? rd_run + 1 : 0;

    always @* begin
        bus.ad_in = 16'hDEAD;
        if (!bus.noe_n && rd_run == int'(T_DATAST))
            bus.ad_in = bus_mem.exists(latch_q) ? bus_mem[latch_q] : dflt(latch_q);
    end

    assign bus2.ad_in = bus2.noe_n ? 16'hDEAD : 16'h1234;

    // Monitor: phase lengths, address/data on the pins, protocol rules, responses.
    int          nadv_run = 0;
    int          stb_run  = 0;
    int          ne_hi_run = 0;
    int unsigned exp_ready_cyc = 0;

    always @(negedge clk) begin
        txn_t t;
        if (!rst_n) begin
            nadv_run  = 0;
            stb_run   = 0;
            ne_hi_run = 0;
        end else begin
            if (!bus.ne_n) begin
                chk("strobe_excl", 32'(!bus.noe_n && !bus.nwe_n), 32'd0);
                chk("ready_busy", 32'(bus.req_ready), 32'd0);
            end
            if (!bus.noe_n) chk("oe_in_read", 32'(bus.ad_oe), 32'd0);

            if (!bus.nadv) begin
                nadv_run++;
                if (sb.size() > 0) chk("addr_phase", 32'({bus.a_hi, bus.ad_out}), 32'(sb[0].addr));
            end else if (nadv_run > 0) begin
                chk("nadv_len", 32'(nadv_run), 32'(T_ADDSET));
                nadv_run = 0;
                if (sb.size() > 0) begin
                    chk("latch_addr", 32'(latch_q), 32'(sb[0].addr));
                    chk("ad_hold", 32'({bus.ad_oe, bus.ad_out}), 32'({1'b1, sb[0].addr[15:0]}));
                end
            end

            if (!bus.noe_n || !bus.nwe_n) begin
                stb_run++;
                if (!bus.nwe_n && sb.size() > 0)
                    chk("wdata", 32'({bus.ad_oe, bus.ad_out}), 32'({1'b1, sb[0].wdata}));
            end else if (stb_run > 0) begin
                chk("strobe_len", 32'(stb_run), 32'(T_DATAST));
                stb_run = 0;
            end

            if (bus.ne_n) begin
                ne_hi_run++;
            end else begin
                if (ne_hi_run > 0 && sb.size() > 0 && sb[0].b2b)
                    chk("ne_gap", 32'(ne_hi_run), 32'(T_BUSTURN + 1));
                ne_hi_run = 0;
            end

            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    t = sb.pop_front();
                    chk("rsp_cycle", cyc, t.rsp_cyc);
                    chk(t.write ? "rsp_hold" : "rsp_rdata", 32'(bus.rsp_rdata), 32'(t.rdata));
                    exp_ready_cyc = cyc + T_BUSTURN;
                end
            end
            if (exp_ready_cyc != 0 && cyc == exp_ready_cyc)
                chk("ready_after", 32'(bus.req_ready), 32'd1);
        end
    end

    // Present one request starting at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic w, input logic [18:0] a, input logic [15:0] d, input bit keep);
        txn_t t;
        int   n;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        t.b2b = !bus.req_ready;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("ready_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        t.write = w;
        t.addr  = a;
        t.wdata = d;
        if (w) begin
            ref_mem[a] = d;
            t.rdata = ref_last_rd;
        end else begin
            t.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            ref_last_rd = t.rdata;
        end
        t.rsp_cyc = cyc + 1 + LAT;
        sb.push_back(t);
        @(negedge clk);
        bus.req_valid = keep;
        bus.req_write = ~w;
        bus.req_addr  = 19'($urandom);
        bus.req_wdata = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !bus.req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] a;
        int unsigned e0, rsp_at, rdy_at, noe_cnt;
        logic [15:0] rd2;

        bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus_mem[19'h58001] = 16'h1234;
        ref_mem[19'h58001] = 16'h1234;

        repeat (3) @(negedge clk);
        chk("rst_ne_n",      32'(bus.ne_n),      32'd1);
        chk("rst_nadv",      32'(bus.nadv),      32'd1);
        chk("rst_noe_n",     32'(bus.noe_n),     32'd1);
        chk("rst_nwe_n",     32'(bus.nwe_n),     32'd1);
        chk("rst_ad_oe",     32'(bus.ad_oe),     32'd0);
        chk("rst_ad_out",    32'(bus.ad_out),    32'd0);
        chk("rst_a_hi",      32'(bus.a_hi),      32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_ready",     32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 19'h50000, 16'hA5C3, 1'b0);
        wait_idle();
        issue(1'b0, 19'h58001, 16'h0000, 1'b0);
        wait_idle();

        issue(1'b1, 19'h00042, 16'h0F0F, 1'b1);
        issue(1'b0, 19'h00042, 16'h0000, 1'b0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            a = {3'($urandom_range(0, 1)), 16'($urandom_range(0, 7))};
            issue(1'($urandom), a, 16'($urandom), 1'b0);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle();

        // Abort a write in its data phase with an asynchronous reset.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 19'h7FFFF;
        bus.req_wdata = 16'hFFFF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("abort_pre_nwe", 32'(bus.nwe_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_nwe_n", 32'(bus.nwe_n), 32'd1);
        chk("abort_ne_n",  32'(bus.ne_n),  32'd1);
        chk("abort_ad_oe", 32'(bus.ad_oe), 32'd0);
        chk("abort_noe_n", 32'(bus.noe_n), 32'd1);
        chk("abort_rsp",   32'(bus.rsp_valid), 32'd0);
        ref_last_rd = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        issue(1'b0, 19'h50000, 16'h0000, 1'b0);
        wait_idle();

        // Minimum-timing instance.
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_rst", 32'(bus2.req_ready), 32'd1);
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b0;
        bus2.req_addr  = 19'h00123;
        e0 = cyc + 1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        rsp_at = 0; rdy_at = 0; noe_cnt = 0; rd2 = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            if (bus2.rsp_valid && rsp_at == 0) begin
                rsp_at = cyc;
                rd2 = bus2.rsp_rdata;
            end
            if (!bus2.noe_n) noe_cnt++;
            if (bus2.req_ready && rdy_at == 0) rdy_at = cyc;
            @(negedge clk);
        end
        chk("t6_rsp_cycle",   rsp_at,  e0 + 3);
        chk("t6_ready_cycle", rdy_at,  e0 + 4);
        chk("t6_noe_len",     noe_cnt, 32'd1);
        chk("t6_rdata",       32'(rd2), 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
